// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its arbiter.
package mem_pkg;

  localparam int MEM_WORD_W   = 32;
  localparam int MEM_ADDR_W   = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data grant selection: data wins ties unless the fetch port has been
// passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  output logic if_grant,
  output logic d_grant
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starved;

  assign starved = (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT));

  always_comb begin
    if_grant = 1'b0;
    d_grant  = 1'b0;
    if (idle) begin
      if (d_valid && !(if_valid && starved)) begin
        d_grant = 1'b1;
      end else if (if_valid) begin
        if_grant = 1'b1;
      end
    end
  end

  // Counts data grants taken while a fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_grant) begin
      starve_cnt <= '0;
    end else if (d_grant && if_valid) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding word memory serving an instruction-fetch and a data port.
// Optional per-byte store enables are enabled by defining MEM_BYTE_STROBE_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [MEM_ADDR_W-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [MEM_WORD_W-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [MEM_ADDR_W-1:0] d_req_addr,
  input  logic [MEM_WORD_W-1:0] d_req_wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]            d_req_strb,
`endif
  output logic                  d_rsp_valid,
  output logic [MEM_WORD_W-1:0] d_rsp_rdata,
  output logic                  rsp_err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         NBYTES    = MEM_WORD_W / 8;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  logic if_grant, d_grant, accept, enter_resp;

  logic                  port_d_q, we_q, err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [MEM_WORD_W-1:0] wdata_q, rdata_q;
  logic [NBYTES-1:0]     strb_q;

  logic                  cur_we, cur_err;
  logic [IDX_W-1:0]      cur_idx;
  logic [MEM_WORD_W-1:0] cur_wdata;
  logic [NBYTES-1:0]     cur_strb, req_strb;
  logic [MEM_ADDR_W-1:0] sel_addr;

  logic [MEM_WORD_W-1:0] mem [DEPTH];

`ifdef MEM_BYTE_STROBE_EN
  assign req_strb = d_req_strb;
`else
  assign req_strb = '1;
`endif

  mem_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .idle     ((state == IDLE) && !rst),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .if_grant (if_grant),
    .d_grant  (d_grant)
  );

  assign accept       = if_grant | d_grant;
  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;
  assign sel_addr     = d_grant ? d_req_addr : if_req_addr;

  // With LATENCY 1 the array is touched on the accepting edge, so the live
  // request is used; otherwise the captured copy.
  always_comb begin
    cur_we    = we_q;
    cur_err   = err_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_strb  = strb_q;
    if (state == IDLE) begin
      cur_we    = d_grant & d_req_we;
      cur_err   = (sel_addr >= MEM_ADDR_W'(DEPTH));
      cur_idx   = sel_addr[IDX_W-1:0];
      cur_wdata = d_req_wdata;
      cur_strb  = req_strb;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      port_d_q <= d_grant;
      we_q     <= cur_we;
      err_q    <= cur_err;
      idx_q    <= cur_idx;
      wdata_q  <= cur_wdata;
      strb_q   <= cur_strb;
    end
  end

  // Array access happens only on the edge entering RESP; rst gates it so an
  // abandoned store is never performed.
  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      rdata_q <= (cur_we || cur_err) ? '0 : mem[cur_idx];
      if (cur_we && !cur_err) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (cur_strb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  assign if_rsp_valid = (state == RESP) && !port_d_q;
  assign d_rsp_valid  = (state == RESP) && port_d_q;
  assign if_rsp_data  = if_rsp_valid ? rdata_q : '0;
  assign d_rsp_rdata  = d_rsp_valid ? rdata_q : '0;
  assign rsp_err      = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY 1, one at LATENCY 3.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [31:0] if_req_addr  [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rsp_data  [2];
  logic        d_req_valid  [2];
  logic        d_req_ready  [2];
  logic        d_req_we     [2];
  logic [31:0] d_req_addr   [2];
  logic [31:0] d_req_wdata  [2];
`ifdef MEM_BYTE_STROBE_EN
  logic [3:0]  d_req_strb   [2];
`endif
  logic        d_rsp_valid  [2];
  logic [31:0] d_rsp_rdata  [2];
  logic        rsp_err      [2];

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.DEPTH(4096), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_req_addr(if_req_addr[0]),
    .if_rsp_valid(if_rsp_valid[0]), .if_rsp_data(if_rsp_data[0]),
    .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_req_we(d_req_we[0]),
    .d_req_addr(d_req_addr[0]), .d_req_wdata(d_req_wdata[0]),
`ifdef MEM_BYTE_STROBE_EN
    .d_req_strb(d_req_strb[0]),
`endif
    .d_rsp_valid(d_rsp_valid[0]), .d_rsp_rdata(d_rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH(4096), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_req_addr(if_req_addr[1]),
    .if_rsp_valid(if_rsp_valid[1]), .if_rsp_data(if_rsp_data[1]),
    .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_req_we(d_req_we[1]),
    .d_req_addr(d_req_addr[1]), .d_req_wdata(d_req_wdata[1]),
`ifdef MEM_BYTE_STROBE_EN
    .d_req_strb(d_req_strb[1]),
`endif
    .d_rsp_valid(d_rsp_valid[1]), .d_rsp_rdata(d_rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One request on instance s; returns response data, err and the number of
  // edges from the accepting edge to the edge that sees rsp_valid.
  task automatic xact(input string tag, input int s, input bit dport, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] data, output logic err, output int lat);
    bit acc = 1'b0;
    data = '0;
    err  = 1'b0;
    lat  = -1;
    @(negedge clk);
    if (dport) begin
      d_req_valid[s] = 1'b1;
      d_req_we[s]    = we;
      d_req_addr[s]  = addr;
      d_req_wdata[s] = wdata;
`ifdef MEM_BYTE_STROBE_EN
      d_req_strb[s]  = strb;
`endif
    end else begin
      if_req_valid[s] = 1'b1;
      if_req_addr[s]  = addr;
    end
    for (int t = 0; t < 20; t++) begin
      #1;
      if (dport ? d_req_ready[s] : if_req_ready[s]) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      check({tag, ".accept"}, 32'd0, 32'd1);
      d_req_valid[s]  = 1'b0;
      if_req_valid[s] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the transaction must not notice.
    d_req_valid[s]  = 1'b0;
    if_req_valid[s] = 1'b0;
    d_req_we[s]     = ~we;
    d_req_addr[s]   = ~addr;
    d_req_wdata[s]  = ~wdata;
    if_req_addr[s]  = ~addr;
`ifdef MEM_BYTE_STROBE_EN
    d_req_strb[s]   = ~strb;
`endif
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (dport ? d_rsp_valid[s] : if_rsp_valid[s]) begin
        lat  = n;
        data = dport ? d_rsp_rdata[s] : if_rsp_data[s];
        err  = rsp_err[s];
        break;
      end
    end
    if (lat < 0) begin
      check({tag, ".rsp_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check({tag, ".pulse"}, 32'(dport ? d_rsp_valid[s] : if_rsp_valid[s]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          g;
    byte         order [6];
    string       exp_order;
    bit          seen;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      if_req_valid[s] = 1'b1;
      if_req_addr[s]  = '0;
      d_req_valid[s]  = 1'b1;
      d_req_we[s]     = 1'b0;
      d_req_addr[s]   = '0;
      d_req_wdata[s]  = '0;
`ifdef MEM_BYTE_STROBE_EN
      d_req_strb[s]   = 4'hF;
`endif
    end
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d.if_ready", s), 32'(if_req_ready[s]), 32'd0);
      check($sformatf("rst%0d.d_ready", s), 32'(d_req_ready[s]), 32'd0);
      check($sformatf("rst%0d.rsp_valid", s), 32'(if_rsp_valid[s] | d_rsp_valid[s]), 32'd0);
      check($sformatf("rst%0d.err", s), 32'(rsp_err[s]), 32'd0);
      check($sformatf("rst%0d.data", s), if_rsp_data[s] | d_rsp_rdata[s], 32'd0);
    end
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if_req_valid[s] = 1'b0;
      d_req_valid[s]  = 1'b0;
    end
    rst = 1'b0;

    // Both ports requesting every cycle: D,D,D,D,I,D.
    @(negedge clk);
    if_req_valid[0] = 1'b1;
    if_req_addr[0]  = 32'd0;
    d_req_valid[0]  = 1'b1;
    d_req_we[0]     = 1'b0;
    d_req_addr[0]   = 32'd1;
    g = 0;
    for (int c = 0; c < 60 && g < 6; c++) begin
      #1;
      if (if_req_ready[0] && d_req_ready[0]) check("arb.both_ready", 32'd1, 32'd0);
      if (d_req_ready[0]) begin
        order[g] = "D";
        g++;
      end else if (if_req_ready[0]) begin
        order[g] = "I";
        g++;
      end
      @(negedge clk);
    end
    if_req_valid[0] = 1'b0;
    d_req_valid[0]  = 1'b0;
    check("arb.grants", 32'(g), 32'd6);
    exp_order = "DDDDID";
    for (int k = 0; k < 6; k++) check($sformatf("arb.grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
    repeat (3) @(negedge clk);

    // Store then load, LATENCY 1.
    xact("st5", 0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st5.lat", 32'(lat), 32'd1);
    check("st5.err", 32'(er), 32'd0);
    check("st5.rdata", rd, 32'd0);
    xact("ld5", 0, 1'b1, 1'b0, 32'd5, 32'h0, 4'hF, rd, er, lat);
    check("ld5.lat", 32'(lat), 32'd1);
    check("ld5.err", 32'(er), 32'd0);
    check("ld5.rdata", rd, 32'hDEADBEEF);
    xact("if5", 0, 1'b0, 1'b0, 32'd5, 32'h0, 4'hF, rd, er, lat);
    check("if5.lat", 32'(lat), 32'd1);
    check("if5.data", rd, 32'hDEADBEEF);

    // Range boundary: 4095 is the last word, 4096 aliases index 0 if unchecked.
    xact("st0", 0, 1'b1, 1'b1, 32'd0, 32'h01020304, 4'hF, rd, er, lat);
    xact("st4095", 0, 1'b1, 1'b1, 32'd4095, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    check("st4095.err", 32'(er), 32'd0);
    xact("ld4095", 0, 1'b1, 1'b0, 32'd4095, 32'h0, 4'hF, rd, er, lat);
    check("ld4095.rdata", rd, 32'hA5A5A5A5);
    xact("ld4096", 0, 1'b1, 1'b0, 32'd4096, 32'h0, 4'hF, rd, er, lat);
    check("ld4096.lat", 32'(lat), 32'd1);
    check("ld4096.err", 32'(er), 32'd1);
    check("ld4096.rdata", rd, 32'd0);
    xact("st4096", 0, 1'b1, 1'b1, 32'd4096, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("st4096.err", 32'(er), 32'd1);
    xact("ld0", 0, 1'b1, 1'b0, 32'd0, 32'h0, 4'hF, rd, er, lat);
    check("ld0.rdata", rd, 32'h01020304);
    check("ld0.err", 32'(er), 32'd0);

    // Byte strobes on word 7.
    xact("st7a", 0, 1'b1, 1'b1, 32'd7, 32'h11223344, 4'hF, rd, er, lat);
    xact("st7b", 0, 1'b1, 1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xact("ld7", 0, 1'b1, 1'b0, 32'd7, 32'h0, 4'hF, rd, er, lat);
`ifdef MEM_BYTE_STROBE_EN
    check("ld7.rdata", rd, 32'h11BB33DD);
`else
    check("ld7.rdata", rd, 32'hAABBCCDD);
`endif

    // LATENCY 3 instance.
    xact("l3.st9", 1, 1'b1, 1'b1, 32'd9, 32'h12345678, 4'hF, rd, er, lat);
    check("l3.st9.lat", 32'(lat), 32'd3);
    xact("l3.ld9", 1, 1'b1, 1'b0, 32'd9, 32'h0, 4'hF, rd, er, lat);
    check("l3.ld9.lat", 32'(lat), 32'd3);
    check("l3.ld9.rdata", rd, 32'h12345678);

    // Reset one cycle into a store: it must be abandoned without a write.
    @(negedge clk);
    d_req_valid[1] = 1'b1;
    d_req_we[1]    = 1'b1;
    d_req_addr[1]  = 32'd9;
    d_req_wdata[1] = 32'h55555555;
`ifdef MEM_BYTE_STROBE_EN
    d_req_strb[1]  = 4'hF;
`endif
    #1;
    check("l3.rst.accept", 32'(d_req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    d_req_valid[1] = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    d_req_valid[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("l3.rst.ready%0d", c), 32'(d_req_ready[1]), 32'd0);
      if (d_rsp_valid[1]) seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("l3.rst.ready_after", 32'(d_req_ready[1]), 32'd1);
    d_req_valid[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_rsp_valid[1]) seen = 1'b1;
    end
    check("l3.rst.no_rsp", 32'(seen), 32'd0);
    xact("l3.ld9b", 1, 1'b1, 1'b0, 32'd9, 32'h0, 4'hF, rd, er, lat);
    check("l3.ld9b.rdata", rd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
